// File: rtl/vrf_pkg.sv
// Shared types, default sizes and address helpers for the vector register file.
// Register 0 and out-of-range addresses are both "invalid" for write, read and issue.
package vrf_pkg;

  localparam int NREGS_DEF  = 16;
  localparam int LANES_DEF  = 4;
  localparam int LANE_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [LANE_W_DEF-1:0] lane_t;
  typedef lane_t [LANES_DEF-1:0] vreg_t;

  function automatic logic addr_valid(input int unsigned addr,
                                      input int unsigned nregs = NREGS_DEF);
    return (addr != 0) && (addr < nregs);
  endfunction

endpackage

// File: rtl/vrf_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, set beats clear on the same register.
// Busy outputs and stall are combinational from the registered busy state.
module vrf_scoreboard
  import vrf_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_busy,
  output logic              stall
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [NREGS-1:0] busy;
  logic             set_ok;
  logic             clr_ok;

  assign set_ok = issue && addr_valid(32'(issue_rd), NREGS);
  assign clr_ok = we && addr_valid(32'(rd), NREGS);

  // Clear is applied first so a same-register set overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_ok) busy[rd[IDX_W-1:0]] <= 1'b0;
      if (set_ok) busy[issue_rd[IDX_W-1:0]] <= 1'b1;
    end
  end

  assign rs1_busy = addr_valid(32'(rs1), NREGS) && busy[rs1[IDX_W-1:0]];
  assign rs2_busy = addr_valid(32'(rs2), NREGS) && busy[rs2[IDX_W-1:0]];
  assign rd_busy  = addr_valid(32'(issue_rd), NREGS) && busy[issue_rd[IDX_W-1:0]];
  assign stall    = issue && (rs1_busy || rs2_busy || rd_busy);

endmodule

// File: rtl/vector_regfile.sv
// Vector register file for Decode: two combinational read ports with write-through
// bypass, one lane-masked write port, and a busy scoreboard for pending producers.
module vector_regfile
  import vrf_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       rs1,
  input  logic [ADDR_W-1:0]       rs2,
  output logic [LANES*LANE_W-1:0] rout1,
  output logic [LANES*LANE_W-1:0] rout2,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       rd,
  input  logic [LANES-1:0]        wmask,
  input  logic [LANES*LANE_W-1:0] wdata,
  input  logic                    issue,
  input  logic [ADDR_W-1:0]       issue_rd,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic                    rd_busy,
  output logic                    stall
);

  localparam int VW    = LANES * LANE_W;
  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [VW-1:0] regs [NREGS];
  logic          wr_ok;
  logic [VW-1:0] stored1;
  logic [VW-1:0] stored2;

  assign wr_ok = we && addr_valid(32'(rd), NREGS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < LANES; i++)
        if (wmask[i]) regs[rd[IDX_W-1:0]][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
    end
  end

  // Invalid addresses read zero; a matching write overlays only its masked lanes.
  function automatic logic [VW-1:0] read_port(input logic [ADDR_W-1:0] ra,
                                              input logic [VW-1:0]     stored,
                                              input logic              hit,
                                              input logic [LANES-1:0]  mask,
                                              input logic [VW-1:0]     data);
    logic [VW-1:0] v;
    v = '0;
    if (addr_valid(32'(ra), NREGS)) begin
      v = stored;
      if (hit)
        for (int i = 0; i < LANES; i++)
          if (mask[i]) v[i*LANE_W +: LANE_W] = data[i*LANE_W +: LANE_W];
    end
    return v;
  endfunction

  assign stored1 = regs[rs1[IDX_W-1:0]];
  assign stored2 = regs[rs2[IDX_W-1:0]];
  assign rout1   = read_port(rs1, stored1, wr_ok && (rs1 == rd), wmask, wdata);
  assign rout2   = read_port(rs2, stored2, wr_ok && (rs2 == rd), wmask, wdata);

  vrf_scoreboard #(
    .NREGS (NREGS),
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .issue   (issue),
    .issue_rd(issue_rd),
    .we      (we),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy),
    .rd_busy (rd_busy),
    .stall   (stall)
  );

endmodule

// File: tb/tb_vector_regfile.sv
// Directed bench for vector_regfile: reset, masked write/bypass, register 0 and
// out-of-range handling, scoreboard set/clear priority and asynchronous reset.
module tb_vector_regfile;
  import vrf_pkg::*;

  localparam int VW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1, rs2, rd, issue_rd;
  logic [VW-1:0] rout1, rout2, wdata;
  logic          we, issue;
  logic [3:0]    wmask;
  logic          rs1_busy, rs2_busy, rd_busy, stall;

  int passed = 0;
  int total  = 0;

  vector_regfile dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rout1(rout1), .rout2(rout2),
    .we(we), .rd(rd), .wmask(wmask), .wdata(wdata), .issue(issue),
    .issue_rd(issue_rd), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd_busy(rd_busy), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] vec(input int d, input int c, input int b, input int a);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  // Present one write for a full cycle, then drop we at the next falling edge.
  task automatic do_write(input logic [4:0] a, input logic [3:0] m, input logic [VW-1:0] d);
    we = 1'b1; rd = a; wmask = m; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; we = 1'b0; issue = 1'b0; rd = '0; issue_rd = '0;
    wmask = '0; wdata = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 16; r++) begin
      rs1 = 5'(r); rs2 = 5'(r); issue_rd = 5'(r);
      #1;
      total++;
      if (rout1 !== '0 || rout2 !== '0)
        $display("FAIL reset_read r=%0d got %h / %h want 0", r, rout1, rout2);
      else passed++;
      total++;
      if ({rs1_busy, rs2_busy, rd_busy, stall} !== 4'b0)
        $display("FAIL reset_busy r=%0d got %b want 0000", r, {rs1_busy, rs2_busy, rd_busy, stall});
      else passed++;
    end
    @(negedge clk);
  endtask

  task automatic test_masked_write;
    do_write(5'd3, 4'hf, vec(8, 7, 6, 5));
    rs1 = 5'd3; rs2 = 5'd2;
    we = 1'b1; rd = 5'd3; wmask = 4'b0101; wdata = vec(4, 3, 2, 1);
    #1;
    total++;
    if (rout1 !== vec(8, 3, 6, 1)) $display("FAIL bypass got %h want %h", rout1, vec(8, 3, 6, 1));
    else passed++;
    total++;
    if (rout2 !== '0) $display("FAIL bypass_other_port got %h want 0", rout2);
    else passed++;
    @(negedge clk);
    we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rs2 = 5'd3;
      #1;
      total++;
      if (rout1 !== vec(8, 3, 6, 1) || rout2 !== vec(8, 3, 6, 1))
        $display("FAIL stored_merge k=%0d got %h / %h want %h", k, rout1, rout2, vec(8, 3, 6, 1));
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_zero_oob;
    rs1 = 5'd0; rs2 = 5'd20;
    we = 1'b1; rd = 5'd0; wmask = 4'hf; wdata = '1;
    #1;
    total++;
    if (rout1 !== '0) $display("FAIL reg0_bypass got %h want 0", rout1);
    else passed++;
    @(negedge clk);
    rd = 5'd20;
    #1;
    total++;
    if (rout2 !== '0) $display("FAIL oob_bypass got %h want 0", rout2);
    else passed++;
    @(negedge clk);
    we = 1'b0;
    rs1 = 5'd0; rs2 = 5'd20;
    #1;
    total++;
    if (rout1 !== '0 || rout2 !== '0) $display("FAIL zero_oob_read got %h / %h want 0", rout1, rout2);
    else passed++;
    rs1 = 5'd4; rs2 = 5'd3;
    #1;
    total++;
    if (rout1 !== '0 || rout2 !== vec(8, 3, 6, 1))
      $display("FAIL no_alias_write got %h / %h want 0 / %h", rout1, rout2, vec(8, 3, 6, 1));
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_scoreboard;
    rs1 = 5'd5; rs2 = 5'd0;
    issue = 1'b1; issue_rd = 5'd5;
    #1;
    total++;
    if (rs1_busy !== 1'b0 || stall !== 1'b0) $display("FAIL busy_early got %b%b want 00", rs1_busy, stall);
    else passed++;
    @(negedge clk);
    issue = 1'b0;
    #1;
    total++;
    if (rs1_busy !== 1'b1) $display("FAIL busy_set got %b want 1", rs1_busy);
    else passed++;
    issue = 1'b1; issue_rd = 5'd6;
    #1;
    total++;
    if (stall !== 1'b1 || rd_busy !== 1'b0) $display("FAIL stall got %b rd_busy %b want 1 0", stall, rd_busy);
    else passed++;
    issue = 1'b0;
    we = 1'b1; rd = 5'd5; wmask = 4'b0000; wdata = '1;
    #1;
    total++;
    if (rs1_busy !== 1'b1 || rout1 !== '0) $display("FAIL clear_same_cycle got %b %h want 1 0", rs1_busy, rout1);
    else passed++;
    @(negedge clk);
    we = 1'b0;
    #1;
    total++;
    if (rs1_busy !== 1'b0 || rout1 !== '0) $display("FAIL busy_clear got %b %h want 0 0", rs1_busy, rout1);
    else passed++;
    issue = 1'b1; issue_rd = 5'd20;
    @(negedge clk);
    issue_rd = 5'd0;
    @(negedge clk);
    issue = 1'b0;
    rs1 = 5'd4; rs2 = 5'd0; issue_rd = 5'd20;
    #1;
    total++;
    if ({rs1_busy, rs2_busy, rd_busy} !== 3'b000)
      $display("FAIL oob_issue got %b want 000", {rs1_busy, rs2_busy, rd_busy});
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_same_cycle;
    issue = 1'b1; issue_rd = 5'd7; we = 1'b1; rd = 5'd7; wmask = 4'hf; wdata = vec(1, 1, 1, 1);
    @(negedge clk);
    issue_rd = 5'd9; we = 1'b0;
    @(negedge clk);
    issue = 1'b0; rs1 = 5'd7; rs2 = 5'd9;
    #1;
    total++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) $display("FAIL set_wins got %b%b want 11", rs1_busy, rs2_busy);
    else passed++;
    issue = 1'b1; issue_rd = 5'd8; we = 1'b1; rd = 5'd9; wmask = 4'b0010; wdata = vec(0, 0, 9, 0);
    @(negedge clk);
    issue = 1'b0; we = 1'b0; rs1 = 5'd8; rs2 = 5'd9;
    #1;
    total++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) $display("FAIL set_clear_split got %b%b want 10", rs1_busy, rs2_busy);
    else passed++;
    total++;
    if (rout2 !== vec(0, 0, 9, 0)) $display("FAIL split_data got %h want %h", rout2, vec(0, 0, 9, 0));
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    rs1 = 5'd3; rs2 = 5'd7;
    #1;
    total++;
    if (rout1 !== vec(8, 3, 6, 1) || rs2_busy !== 1'b1)
      $display("FAIL pre_reset got %h %b want %h 1", rout1, rs2_busy, vec(8, 3, 6, 1));
    else passed++;
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (rout1 !== '0 || rout2 !== vec(1, 1, 1, 1) - vec(1, 1, 1, 1) || rs2_busy !== 1'b0)
      $display("FAIL async_reset got %h %h %b want 0 0 0", rout1, rout2, rs2_busy);
    else passed++;
    we = 1'b1; rd = 5'd3; wmask = 4'b1000; wdata = vec(5, 0, 0, 0);
    #1;
    total++;
    if (rout1 !== vec(5, 0, 0, 0)) $display("FAIL reset_bypass got %h want %h", rout1, vec(5, 0, 0, 0));
    else passed++;
    @(negedge clk);
    total++;
    if (rout1 !== vec(5, 0, 0, 0)) $display("FAIL reset_priority got %h want %h", rout1, vec(5, 0, 0, 0));
    else passed++;
    we = 1'b0;
    #1;
    total++;
    if (rout1 !== '0) $display("FAIL reset_blocks_write got %h want 0", rout1);
    else passed++;
    rst = 1'b0;
    rs1 = 5'd8;
    #1;
    total++;
    if (rs1_busy !== 1'b0) $display("FAIL reset_busy8 got %b want 0", rs1_busy);
    else passed++;
    do_write(5'd7, 4'b0001, vec(0, 0, 0, 42));
    #1;
    total++;
    if (rout2 !== vec(0, 0, 0, 42) || rs2_busy !== 1'b0)
      $display("FAIL post_reset_wb got %h %b want %h 0", rout2, rs2_busy, vec(0, 0, 0, 42));
    else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_masked_write;
    test_zero_oob;
    test_scoreboard;
    test_same_cycle;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got no finish want finish by 20000");
    $fatal(1, "timeout");
  end

endmodule
